// File: rtl/pipelined_rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder.
package pipelined_rca_pkg;

  // Legal shapes: at least 2 bits wide, at least one stage, and every stage gets the same chunk size
  function automatic bit rca_params_ok(input int width, input int stages);
    if (stages < 1) return 1'b0;
    return (width >= 2) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder slice. Also exposes the carry into
// its top bit so the final slice can form the signed overflow flag.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [W:0] c;

  // Ripple the carry bit by bit through the slice
  always_comb begin
    c[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign sum_o  = a_i ^ b_i ^ c[W-1:0];
  assign cout_o = c[W];
  assign cmsb_o = c[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: stage k adds chunk k of the operands using the
// carry registered by stage k-1. Not-yet-added operand bits travel with their
// operation, and finished low sum bits accumulate stage by stage. The whole
// pipe advances together whenever the output slot is empty or being drained.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = (STAGES >= 1) ? WIDTH / STAGES : 1;

  if (!rca_params_ok(WIDTH, STAGES)) begin : g_param_chk
    $fatal(1, "pipelined_rca: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  // Single advance enable: any stall at the output freezes every stage
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;

    // Operand bits still to be added (this chunk and above), plus incoming carry/valid
    logic [WIDTH-1:LO] a_in, b_in;
    logic              c_in, v_in;
    logic [CHUNK-1:0]  ch_sum;
    logic              ch_c;
    logic [HI-1:0]     s_d, s_q;
    logic              c_q, v_q;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b;
      assign c_in = cin;
      assign v_in = in_valid;
      assign s_d  = ch_sum;
    end else begin : g_link
      assign a_in = g_stg[k-1].g_body.a_q;
      assign b_in = g_stg[k-1].g_body.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
      assign s_d  = {ch_sum, g_stg[k-1].s_q};
    end

    if (k == STAGES - 1) begin : g_tail
      logic ch_m;
      logic ovf_q;

      rca_chunk #(.W(CHUNK)) u_chunk (
        .a_i    (a_in[HI-1:LO]),
        .b_i    (b_in[HI-1:LO]),
        .cin_i  (c_in),
        .sum_o  (ch_sum),
        .cout_o (ch_c),
        .cmsb_o (ch_m)
      );

      // Signed overflow is only meaningful once the MSB chunk has been added
      always_ff @(posedge clk) begin
        if (rst)     ovf_q <= 1'b0;
        else if (en) ovf_q <= ch_c ^ ch_m;
      end
    end else begin : g_body
      logic             unused_cmsb;
      logic [WIDTH-1:HI] a_q, b_q;

      rca_chunk #(.W(CHUNK)) u_chunk (
        .a_i    (a_in[HI-1:LO]),
        .b_i    (b_in[HI-1:LO]),
        .cin_i  (c_in),
        .sum_o  (ch_sum),
        .cout_o (ch_c),
        .cmsb_o (unused_cmsb)
      );

      // Carry the untouched upper operand chunks along with their operation
      always_ff @(posedge clk) begin
        if (en) begin
          a_q <= a_in[WIDTH-1:HI];
          b_q <= b_in[WIDTH-1:HI];
        end
      end
    end

    // Stage result: valid bit, carry out of this chunk, and all sum bits finished so far
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= ch_c;
        s_q <= s_d;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = g_stg[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: a 16-bit/4-stage instance driven by directed and
// random streams against an arithmetic scoreboard, plus a 10-bit/1-stage
// instance exercising the degenerate registered-adder shape.
module tb_pipelined_rca;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int W1 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  a, b, sum;
  logic          in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1;
  logic [W1-1:0] a1, b1, sum1;

  pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_rca #(.WIDTH(W1), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference: {ovf, cout, sum} of a w-bit add, from plain integer arithmetic
  function automatic logic [W+1:0] ref_add(input int w, input longint av, input longint bv, input bit c);
    longint t, half, sa, sb, r;
    t    = av + bv + longint'(c);
    half = longint'(1) << (w - 1);
    sa   = (av >= half) ? av - 2 * half : av;
    sb   = (bv >= half) ? bv - 2 * half : bv;
    r    = sa + sb + longint'(c);
    ref_add        = '0;
    ref_add[W-1:0] = W'(t % (2 * half));
    ref_add[W]     = (t >= 2 * half);
    ref_add[W+1]   = (r >= half) || (r < -half);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the 4-stage DUT: drive, check outputs against the scoreboard, update it
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic ordy);
    logic          exp_ov;
    logic [W+1:0]  r;
    exp_t          e;
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    @(negedge clk);
    exp_ov = (q.size() > 0) && (q[0].due <= cyc);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_ov || ordy)});
    if (exp_ov) begin
      chk("sum", {16'd0, sum}, {16'd0, q[0].s});
      chk("cout", {31'd0, cout}, {31'd0, q[0].co});
      chk("ovf", {31'd0, ovf}, {31'd0, q[0].ov});
    end
    if (exp_ov && ordy) begin
      void'(q.pop_front());
    end else if (exp_ov) begin
      // output stalled: everything in flight is frozen one more cycle
      for (int i = 0; i < q.size(); i++) begin
        e = q[i]; e.due++; q[i] = e;
      end
    end
    if (iv && (!exp_ov || ordy)) begin
      r     = ref_add(W, longint'(ia), longint'(ib), ic);
      e.s   = r[W-1:0];
      e.co  = r[W];
      e.ov  = r[W+1];
      e.due = cyc + S;
      q.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; out_ready = 1'b0;
    repeat (n) begin @(posedge clk); #1; cyc++; end
    q.delete();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
    rst = 1'b0;
  endtask

  // One back-to-back operation on the single-stage DUT, checked one cycle later
  task automatic step1(input logic [W1-1:0] ia, input logic [W1-1:0] ib, input logic ic);
    logic [W+1:0] r;
    in_valid1 = 1'b1; a1 = ia; b1 = ib; cin1 = ic;
    @(negedge clk);
    chk("s1_in_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk); #1;
    r = ref_add(W1, longint'(ia), longint'(ib), ic);
    chk("s1_out_valid", {31'd0, out_valid1}, 32'd1);
    chk("s1_sum", {22'd0, sum1}, {22'd0, r[W1-1:0]});
    chk("s1_cout", {31'd0, cout1}, {31'd0, r[W]});
    chk("s1_ovf", {31'd0, ovf1}, {31'd0, r[W+1]});
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    pulse_reset(2);

    // single op: result after exactly S cycles, out_valid low before that
    step(1'b1, 16'd598, 16'd1024, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // wrap to zero with carry out, and positive signed overflow
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // carry crossing each chunk boundary
    step(1'b1, 16'h000F, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'h0FFF, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // back-to-back stream
    step(1'b1, 16'd2,    16'd98,   1'b0, 1'b1);
    step(1'b1, 16'd217,  16'd298,  1'b0, 1'b1);
    step(1'b1, 16'd222,  16'd555,  1'b0, 1'b1);
    step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // same stream, held for 3 cycles while 515 sits at the output; offered ops must be ignored
    step(1'b1, 16'd2,    16'd98,   1'b0, 1'b1);
    step(1'b1, 16'd217,  16'd298,  1'b0, 1'b1);
    step(1'b1, 16'd222,  16'd555,  1'b0, 1'b1);
    step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // reset with three operations in flight: nothing from before may emerge
    step(1'b1, 16'd11, 16'd22, 1'b0, 1'b1);
    step(1'b1, 16'd33, 16'd44, 1'b1, 1'b1);
    step(1'b1, 16'd55, 16'd66, 1'b0, 1'b1);
    pulse_reset(1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 16'd100, 16'd23, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // random traffic with bubbles and back-pressure
    repeat (300) begin
      logic [W-1:0] ra, rb;
      ra = rnd_op();
      rb = rnd_op();
      step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    repeat (12) step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drained", q.size(), 32'd0);

    // single-stage shape: registered adder, latency 1
    // (b=1024 does not fit 10 bits, so the wrapping case uses 598+1000)
    step1(10'd598, 10'd1000, 1'b0);
    step1(10'h3FF, 10'h001, 1'b0);
    step1(10'h1FF, 10'h001, 1'b0);
    step1(10'h200, 10'h200, 1'b1);
    repeat (20) step1(W1'($urandom), W1'($urandom), 1'($urandom_range(0, 1)));
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("s1_idle_out_valid", {31'd0, out_valid1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
